// File: rtl/b01_pkg.sv
// Shared types and helpers for the b01 serial adder/comparator FSM.
// Optional build macro: B01_OBS_EN (adds the obs_state observation port).
package b01_pkg;

  // State encodings are fixed; obs_state exposes them directly.
  typedef enum logic [2:0] {
    ST_A   = 3'd0,
    ST_B   = 3'd1,
    ST_C   = 3'd2,
    ST_E   = 3'd3,
    ST_F   = 3'd4,
    ST_G   = 3'd5,
    ST_WF0 = 3'd6,
    ST_WF1 = 3'd7
  } state_t;

  localparam logic [2:0] OBS_IDLE = 3'd0;

  // Result bit select: carry-pending states emit the inverted sum bit.
  function automatic logic sel_out(input logic x, input logic invert);
    return invert ? ~x : x;
  endfunction

endpackage

// File: rtl/b01_serial_adder.sv
// b01_serial_adder: Mealy FSM adding/comparing two serial bit streams over a
// 4-bit frame (A/E -> B/F -> C/G -> WF0/WF1 -> A/E). F, G and WF1 carry a
// pending carry; E flags overflow on the edge that leaves it.
// Optional build macro: B01_OBS_EN adds a registered obs_state[2:0] port that
// shows the current state encoding one edge after __obs is high.
module b01_serial_adder
  import b01_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       line1,
  input  logic       line2,
  input  logic       __obs,
  output logic       outp,
  output logic       overflw
`ifdef B01_OBS_EN
  ,
  output logic [2:0] obs_state
`endif
);

  state_t state;

  logic bit_x;
  logic bit_and;
  logic bit_or;

  // Per-edge combinations of the two serial input bits.
  assign bit_x   = line1 ^ line2;
  assign bit_and = line1 & line2;
  assign bit_or  = line1 | line2;

  // Next state and both outputs update together; reset wins over every transition.
  // NOTE: reset is sampled synchronously here, and all state uses <= so every
  // register sees the pre-edge value of state in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_A;
      outp    <= 1'b0;
      overflw <= 1'b0;
    end else begin
      case (state)
        ST_A: begin
          state   <= bit_and ? ST_F : ST_B;
          outp    <= sel_out(bit_x, 1'b0);
          overflw <= 1'b0;
        end
        ST_E: begin
          state   <= bit_and ? ST_F : ST_B;
          outp    <= sel_out(bit_x, 1'b0);
          overflw <= 1'b1;
        end
        ST_B: begin
          state   <= bit_and ? ST_G : ST_C;
          outp    <= sel_out(bit_x, 1'b0);
          overflw <= 1'b0;
        end
        ST_F: begin
          state   <= bit_or ? ST_G : ST_C;
          outp    <= sel_out(bit_x, 1'b1);
          overflw <= 1'b0;
        end
        ST_C: begin
          state   <= bit_and ? ST_WF1 : ST_WF0;
          outp    <= sel_out(bit_x, 1'b0);
          overflw <= 1'b0;
        end
        ST_G: begin
          state   <= bit_or ? ST_WF1 : ST_WF0;
          outp    <= sel_out(bit_x, 1'b1);
          overflw <= 1'b0;
        end
        ST_WF0: begin
          state   <= bit_and ? ST_E : ST_A;
          outp    <= sel_out(bit_x, 1'b0);
          overflw <= 1'b0;
        end
        ST_WF1: begin
          state   <= bit_or ? ST_E : ST_A;
          outp    <= sel_out(bit_x, 1'b1);
          overflw <= 1'b0;
        end
        default: begin
          state   <= ST_A;
          outp    <= 1'b0;
          overflw <= 1'b0;
        end
      endcase
    end
  end

`ifdef B01_OBS_EN
  // Snapshot of the current state while the observation strobe is high.
  always_ff @(posedge clock) begin
    if (reset) begin
      obs_state <= OBS_IDLE;
    end else begin
      obs_state <= __obs ? state : OBS_IDLE;
    end
  end
`else
  // Strobe has no function in this build; tie it off so it stays visibly unused.
  logic unused_obs;
  assign unused_obs = __obs;
`endif

endmodule

// File: tb/tb_b01_serial_adder.sv
// Directed self-checking bench for b01_serial_adder. Expected outputs are
// written out by hand per step, pushed to a scoreboard when the inputs are
// driven and popped after the clock edge that produces them.
module tb_b01_serial_adder;

  logic       clock;
  logic       reset;
  logic       line1;
  logic       line2;
  logic       obs;
  logic       outp;
  logic       overflw;
`ifdef B01_OBS_EN
  logic [2:0] obs_state;
`endif

  typedef struct packed {
    logic       outp;
    logic       overflw;
    logic [2:0] obs;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  int    errors = 0;
  int    checks = 0;

  b01_serial_adder dut (
    .clock   (clock),
    .reset   (reset),
    .line1   (line1),
    .line2   (line2),
    .__obs   (obs),
    .outp    (outp),
    .overflw (overflw)
`ifdef B01_OBS_EN
    ,
    .obs_state (obs_state)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one edge's inputs, record what the edge must produce, then compare.
  task automatic step(input logic l1, input logic l2, input logic ob,
                      input logic e_outp, input logic e_ovf,
                      input logic [2:0] e_obs, input string tag);
    exp_t e;
    line1 = l1;
    line2 = l2;
    obs   = ob;
    e.outp    = e_outp;
    e.overflw = e_ovf;
    e.obs     = e_obs;
    sb.push_back(e);
    tags.push_back(tag);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    tag = tags.pop_front();
    checks++;
    assert (outp === e.outp) else begin
      errors++;
      $error("FAIL %s outp got=%b want=%b", tag, outp, e.outp);
    end
    checks++;
    assert (overflw === e.overflw) else begin
      errors++;
      $error("FAIL %s overflw got=%b want=%b", tag, overflw, e.overflw);
    end
`ifdef B01_OBS_EN
    checks++;
    assert (obs_state === e.obs) else begin
      errors++;
      $error("FAIL %s obs_state got=%0d want=%0d", tag, obs_state, e.obs);
    end
`endif
  endtask

  initial begin
    reset = 1'b0;
    line1 = 1'b0;
    line2 = 1'b0;
    obs   = 1'b0;
    @(posedge clock);
    #1;

    // Reset with both inputs high: state A, outputs cleared.
    reset = 1'b1;
    step(1, 1, 1, 0, 0, 3'd0, "reset");
    reset = 1'b0;

    // No-carry frame: A->B->C->WF0->A.
    step(1, 0, 0, 1, 0, 3'd0, "nc_a");
    step(0, 1, 0, 1, 0, 3'd0, "nc_b");
    step(1, 0, 0, 1, 0, 3'd0, "nc_c");
    step(0, 1, 0, 1, 0, 3'd0, "nc_wf0");

    // Carry chain: A->F->G->WF1->E, then E->B raises overflw once.
    step(1, 1, 0, 0, 0, 3'd0, "cc_a");
    step(1, 1, 0, 1, 0, 3'd0, "cc_f");
    step(1, 1, 0, 1, 0, 3'd0, "cc_g");
    step(1, 0, 0, 0, 0, 3'd0, "cc_wf1");
    step(0, 0, 0, 0, 1, 3'd0, "cc_e_ovf");
    step(0, 0, 0, 0, 0, 3'd0, "cc_b_ovf_clr");
    step(0, 0, 0, 0, 0, 3'd0, "cc_c");
    step(0, 0, 0, 0, 0, 3'd0, "cc_wf0");

    // Carry drop: A->F->C->WF0->A.
    step(1, 1, 0, 0, 0, 3'd0, "cd_a");
    step(0, 0, 0, 1, 0, 3'd0, "cd_f");
    step(0, 0, 0, 0, 0, 3'd0, "cd_c");
    step(0, 0, 0, 0, 0, 3'd0, "cd_wf0");

    // Remaining arcs: F->G on one bit, G->WF0, WF0->E, E->F, C->WF1, WF1->A.
    step(1, 1, 0, 0, 0, 3'd0, "x_a_f");
    step(0, 1, 0, 0, 0, 3'd0, "x_f_g");
    step(0, 0, 0, 1, 0, 3'd0, "x_g_wf0");
    step(1, 1, 0, 0, 0, 3'd0, "x_wf0_e");
    step(1, 1, 0, 0, 1, 3'd0, "x_e_f");
    step(0, 0, 0, 1, 0, 3'd0, "x_f_c");
    step(1, 1, 0, 0, 0, 3'd0, "x_c_wf1");
    step(0, 0, 0, 1, 0, 3'd0, "x_wf1_a");
    // A->B->G->WF1->E->B->C->WF0->A.
    step(0, 1, 0, 1, 0, 3'd0, "y_a_b");
    step(1, 1, 0, 0, 0, 3'd0, "y_b_g");
    step(1, 0, 0, 0, 0, 3'd0, "y_g_wf1");
    step(0, 1, 0, 0, 0, 3'd0, "y_wf1_e");
    step(1, 0, 0, 1, 1, 3'd0, "y_e_b");
    step(1, 0, 0, 1, 0, 3'd0, "y_b_c");
    step(0, 1, 0, 1, 0, 3'd0, "y_c_wf0");
    step(1, 0, 0, 1, 0, 3'd0, "y_wf0_a");

    // Reset mid-frame from G, then resume from A.
    step(1, 1, 0, 0, 0, 3'd0, "rm_a");
    step(1, 1, 0, 1, 0, 3'd0, "rm_f");
    reset = 1'b1;
    step(1, 1, 0, 0, 0, 3'd0, "rm_reset");
    reset = 1'b0;
    step(1, 1, 0, 0, 0, 3'd0, "rm_a_f");
    step(1, 0, 0, 0, 0, 3'd0, "rm_f_g");
    step(0, 1, 0, 0, 0, 3'd0, "rm_g_wf1");

    // Observation strobe in WF1, then strobe low.
    step(0, 0, 1, 1, 0, 3'd7, "obs_wf1");
    step(0, 0, 0, 0, 0, 3'd0, "obs_off");
    step(0, 0, 1, 0, 0, 3'd1, "obs_b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout after 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
